bl_d1_xpose_buf: RTL
====================

# bl_d1_xpose_buf

8x8 transpose buffer for the JPEG decode IDCT. It takes the eight 9-bit row-pass result streams from the `bl_d1` row stage, stores one 8x8 block per bank, and re-emits it column-wise on eight 9-bit streams to the column-pass stage. Two ping-pong banks let a block be written while the previous one is read. End-of-stream tokens are forwarded in order.

## Interface
Parameters:
- `W`, 9: sample width.

Ports (every stream carries `_d` data, `_e` end-of-stream flag, `_v` valid, and `_b` back-pressure):
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `a_d..h_d`  in  W each  row element 0..7 of the current row.
- `a_e..h_e`, `a_v..h_v`  in  1 each  input EOS flag and valid.
- `a_b..h_b`  out  1 each  input back-pressure. All eight are driven identically.
- `s_d..z_d`  out  W each  column element 0..7 (row index 0..7) of the current column.
- `s_e..z_e`, `s_v..z_v`  out  1 each  output EOS flag and valid. All eight are driven identically.
- `s_b..z_b`  in  1 each  output back-pressure.

## Operation
- **Input transfer.** A row transfers on a cycle when all of `a_v..h_v` are 1 and `a_b`=0. Lanes are never consumed partially.
- **EOS token.** The input token is an EOS token if any `*_e` is 1. Its data is ignored.
- **Output transfer.** An output column transfers on a cycle when `s_v`=1 and all of `s_b..z_b` are 0.
- **Storage.** Bank state: `wsel`, `rsel`, a 3-bit write row counter `wr`, a 3-bit read column counter `rc`, a 4-bit `rows[bank]` count, and a `full[bank]` flag.
- **Write path.** Row r is written as M[r][0..7] = a..h into bank `wsel`. `wr` increments on each row. After the 8th row (`wr`=7 → wrap to 0), `full[wsel]` is set, `rows` is set to 8, and `wsel` toggles.
- **Read path.** When `full[rsel]`=1, `s_v`=1 and lane k outputs M[k][rc], so s carries row 0 and z carries row 7. `rc` increments per output transfer. After column 7, `full[rsel]` is cleared and `rsel` toggles.
- **Partial rows.** Rows with index >= `rows[rsel]` read as 0.
- **EOS at `wr`=0.** The EOS token is accepted and sets `eos_pend`.
- **EOS at `wr`=k>0 (partial block).** The EOS token is accepted. The current bank is committed as full with `rows`=k, so rows k..7 are zero-filled, and `wsel` toggles. `eos_pend` is then set.
- **While `eos_pend`=1.**
  - `a_b`=1.
  - Once both banks are empty, the outputs present `s_v`=1, `s_e`=1, `*_d`=0.
  - When that token transfers, `eos_pend` clears and `wr`, `wsel` and `rsel` return to 0.
- **Input back-pressure.** `a_b` = `eos_pend` | `full[wsel]`.
- **Simultaneous events.** If the same cycle completes both a bank write and a bank read, both updates apply. A bank freed on a cycle becomes writable on the next cycle; there is no same-cycle bypass.
- **Reset.** Reset may assert at any time, including mid-block. The asynchronous reset discards all stored data and clears all counters, flags and `eos_pend`.

## Timing
- **Reset values.** All `*_v`=0, all `*_e`=0, all `*_d`=0, `a_b..h_b`=0, both banks empty, `wsel`=`rsel`=0.
- **Output paths.** `*_v`, `*_e` and `a_b` are decoded from registered state only. There is no combinational path from any `*_v` to any `*_b`. `*_d` is a registered-bank read muxed by `rc`.
- **Latency.** If the 8th row transfers at edge N, column 0 is valid in the cycle following edge N.
- **Throughput.** Sustained at 1 row/cycle in and 1 column/cycle out with no bubbles, provided downstream never back-pressures.
- **Stalls.** Output stalls hold `*_d`, `*_v` and `*_e` stable until the transfer occurs.

## Configuration
- `BL_XPOSE_DBUF_EN` defined: two ping-pong banks, behaving as described above.
- `BL_XPOSE_DBUF_EN` undefined:
  - Single bank only; `wsel` and `rsel` are tied to 0.
  - `a_b`=1 from bank full until column 7 transfers, so the input stalls 8 cycles per block. Block period is 16 cycles minimum.
  - Input is re-enabled on the cycle after column 7 transfers. All other behaviour, including EOS handling, is unchanged.

## Test plan
- **Basic transpose.** Write one block with M[r][c]=8r+c and no back-pressure → columns c=0..7 emitted with s_d=c, t_d=8+c, …, z_d=56+c; the first column is valid in the cycle after the 8th row.
- **Back-to-back blocks (DBUF on).** Stream 3 blocks with no back-pressure → `a_b` never asserts; 24 output columns appear contiguously after an 8-cycle fill.
- **Back-pressure.** Hold `x_b`=1 for 5 cycles mid-column 3 → outputs are held stable with no column lost or duplicated. Sustained `s_b`=1 → `a_b`=1 after 16 rows (8 with DBUF off).
- **Partial block then EOS.** Send 3 rows then EOS → 8 columns emitted with lanes v..z = 0, followed by one token with `*_e`=1, then `a_b`=0.
- **Lane skew.** Assert `a_v..g_v`=1 and `h_v`=0 for 4 cycles → no write occurs (`wr` unchanged); the row is written on the cycle `h_v` rises.
- **Reset mid-block.** Pulse reset after 5 rows → all `*_v`=0 immediately; the next full block written is emitted correctly with no stale data.

Source files
------------

// File: rtl/bl_d1_xpose_buf.sv
// -----------------------------------------------------------------------------
// bl_d1_xpose_buf
// 8x8 transpose buffer between the bl_d1 IDCT row pass and the column pass.
// Rows arrive on eight W-bit lanes (a..h = row elements 0..7). Each block is
// stored whole and leaves column by column on eight lanes (s..z = rows 0..7).
// End-of-stream tokens are forwarded in order, after all buffered data.
//
// Ports
//   clock, reset         rising-edge clock, asynchronous active-high reset
//   a_d..h_d             in  W  row element 0..7
//   a_e..h_e, a_v..h_v   in  1  per-lane EOS flag and valid
//   a_b..h_b             out 1  input back-pressure (all lanes identical)
//   s_d..z_d             out W  column element for row 0..7
//   s_e..z_e, s_v..z_v   out 1  output EOS flag and valid (all lanes identical)
//   s_b..z_b             in  1  output back-pressure
//
// Build option
//   BL_XPOSE_DBUF_EN     defined: two ping-pong banks (write one, read other).
//                        undefined: one bank; input stalls while it drains.
// -----------------------------------------------------------------------------
module bl_d1_xpose_buf #(
    parameter int unsigned W = 9
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] a_d,
    input  logic [W-1:0] b_d,
    input  logic [W-1:0] c_d,
    input  logic [W-1:0] d_d,
    input  logic [W-1:0] e_d,
    input  logic [W-1:0] f_d,
    input  logic [W-1:0] g_d,
    input  logic [W-1:0] h_d,
    input  logic         a_e,
    input  logic         b_e,
    input  logic         c_e,
    input  logic         d_e,
    input  logic         e_e,
    input  logic         f_e,
    input  logic         g_e,
    input  logic         h_e,
    input  logic         a_v,
    input  logic         b_v,
    input  logic         c_v,
    input  logic         d_v,
    input  logic         e_v,
    input  logic         f_v,
    input  logic         g_v,
    input  logic         h_v,
    output logic         a_b,
    output logic         b_b,
    output logic         c_b,
    output logic         d_b,
    output logic         e_b,
    output logic         f_b,
    output logic         g_b,
    output logic         h_b,
    output logic [W-1:0] s_d,
    output logic [W-1:0] t_d,
    output logic [W-1:0] u_d,
    output logic [W-1:0] v_d,
    output logic [W-1:0] w_d,
    output logic [W-1:0] x_d,
    output logic [W-1:0] y_d,
    output logic [W-1:0] z_d,
    output logic         s_e,
    output logic         t_e,
    output logic         u_e,
    output logic         v_e,
    output logic         w_e,
    output logic         x_e,
    output logic         y_e,
    output logic         z_e,
    output logic         s_v,
    output logic         t_v,
    output logic         u_v,
    output logic         v_v,
    output logic         w_v,
    output logic         x_v,
    output logic         y_v,
    output logic         z_v,
    input  logic         s_b,
    input  logic         t_b,
    input  logic         u_b,
    input  logic         v_b,
    input  logic         w_b,
    input  logic         x_b,
    input  logic         y_b,
    input  logic         z_b
);

`ifdef BL_XPOSE_DBUF_EN
    localparam bit DBUF = 1'b1;
`else
    localparam bit DBUF = 1'b0;
`endif
    localparam int unsigned NL = 8;
    localparam int unsigned RW = NL * W;

    // Stored blocks: mem_q[bank][row], element c of a row at [c*W +: W]
    logic [RW-1:0] mem_q [2][NL];

    logic          wsel_q, wsel_d;
    logic          rsel_q, rsel_d;
    logic [2:0]    wr_q,   wr_d;
    logic [2:0]    rc_q,   rc_d;
    logic [3:0]    rows_q [2];
    logic [3:0]    rows_d [2];
    logic [1:0]    full_q, full_d;
    logic          eos_q,  eos_d;

    logic [RW-1:0] row_w;
    logic          in_all_v_c, in_eos_c, out_bp_c;
    logic          in_b_c, data_v_c, tok_v_c, out_v_c;
    logic          in_xfer_c, out_xfer_c;
    logic [W-1:0]  col_c [NL];

    // Input row and lane-wide handshake reductions
    assign row_w      = {h_d, g_d, f_d, e_d, d_d, c_d, b_d, a_d};
    assign in_all_v_c = &{a_v, b_v, c_v, d_v, e_v, f_v, g_v, h_v};
    assign in_eos_c   = |{a_e, b_e, c_e, d_e, e_e, f_e, g_e, h_e};
    assign out_bp_c   = |{s_b, t_b, u_b, v_b, w_b, x_b, y_b, z_b};

    // Handshake decode, from registered state only
    assign in_b_c     = eos_q | full_q[wsel_q];
    assign data_v_c   = full_q[rsel_q];
    assign tok_v_c    = eos_q & ~(|full_q);
    assign out_v_c    = data_v_c | tok_v_c;
    assign in_xfer_c  = in_all_v_c & ~in_b_c;
    assign out_xfer_c = out_v_c & ~out_bp_c;

    // Column read: lane k is row k at column rc; rows past the committed count read 0
    always_comb begin
        for (int k = 0; k < NL; k++) begin
            col_c[k] = '0;
            if (data_v_c && (4'(k) < rows_q[rsel_q]))
                col_c[k] = mem_q[rsel_q][3'(k)][32'(rc_q) * W +: W];
        end
    end

    // Next-state: write/commit path, then read/release path; both may apply
    always_comb begin
        wsel_d = wsel_q;
        rsel_d = rsel_q;
        wr_d   = wr_q;
        rc_d   = rc_q;
        rows_d = rows_q;
        full_d = full_q;
        eos_d  = eos_q;

        if (in_xfer_c) begin
            if (in_eos_c) begin
                eos_d = 1'b1;
                // Partial block: commit what was written, the rest reads as zero
                if (wr_q != 3'd0) begin
                    full_d[wsel_q] = 1'b1;
                    rows_d[wsel_q] = 4'(wr_q);
                    wsel_d         = DBUF & ~wsel_q;
                    wr_d           = 3'd0;
                end
            end else begin
                wr_d = wr_q + 3'd1;
                if (wr_q == 3'd7) begin
                    full_d[wsel_q] = 1'b1;
                    rows_d[wsel_q] = 4'd8;
                    wsel_d         = DBUF & ~wsel_q;
                end
            end
        end

        if (out_xfer_c) begin
            if (data_v_c) begin
                rc_d = rc_q + 3'd1;
                if (rc_q == 3'd7) begin
                    full_d[rsel_q] = 1'b0;
                    rsel_d         = DBUF & ~rsel_q;
                end
            end else begin
                // EOS token delivered: return to the start-of-stream state
                eos_d  = 1'b0;
                wr_d   = 3'd0;
                wsel_d = 1'b0;
                rsel_d = 1'b0;
            end
        end
    end

    // Control state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wsel_q    <= 1'b0;
            rsel_q    <= 1'b0;
            wr_q      <= 3'd0;
            rc_q      <= 3'd0;
            rows_q[0] <= 4'd0;
            rows_q[1] <= 4'd0;
            full_q    <= 2'b00;
            eos_q     <= 1'b0;
        end else begin
            wsel_q <= wsel_d;
            rsel_q <= rsel_d;
            wr_q   <= wr_d;
            rc_q   <= rc_d;
            rows_q <= rows_d;
            full_q <= full_d;
            eos_q  <= eos_d;
        end
    end

    // Row storage; stale contents are never visible because reads are gated by full/rows
    always_ff @(posedge clock) begin
        if (in_xfer_c && !in_eos_c)
            mem_q[wsel_q][wr_q] <= row_w;
    end

    // Lane fan-out
    assign a_b = in_b_c;
    assign b_b = in_b_c;
    assign c_b = in_b_c;
    assign d_b = in_b_c;
    assign e_b = in_b_c;
    assign f_b = in_b_c;
    assign g_b = in_b_c;
    assign h_b = in_b_c;

    assign s_d = col_c[0];
    assign t_d = col_c[1];
    assign u_d = col_c[2];
    assign v_d = col_c[3];
    assign w_d = col_c[4];
    assign x_d = col_c[5];
    assign y_d = col_c[6];
    assign z_d = col_c[7];

    assign s_v = out_v_c;
    assign t_v = out_v_c;
    assign u_v = out_v_c;
    assign v_v = out_v_c;
    assign w_v = out_v_c;
    assign x_v = out_v_c;
    assign y_v = out_v_c;
    assign z_v = out_v_c;

    assign s_e = tok_v_c;
    assign t_e = tok_v_c;
    assign u_e = tok_v_c;
    assign v_e = tok_v_c;
    assign w_e = tok_v_c;
    assign x_e = tok_v_c;
    assign y_e = tok_v_c;
    assign z_e = tok_v_c;

endmodule
